// File: rtl/spell_prefetch.sv
// spell_prefetch: instruction prefetcher between the spell execute core and
// internal code memory. Fetches sequential code bytes through the memory
// select/data_ready handshake into a DEPTH-entry FIFO that the core pops.
// A jump (pc_load) flushes the FIFO and restarts fetch at pc_value;
// bus_hold yields the memory bus to core data accesses.
// Optional build macro: SPELL_PREFETCH_STATS_EN adds the stall_count port.
module spell_prefetch #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pc_load,
   input  logic [7:0] pc_value,
   input  logic       bus_hold,
   output logic       instr_valid,
   output logic [7:0] instr_data,
   output logic [7:0] instr_addr,
   input  logic       instr_ready,
   output logic       mem_select,
   output logic [7:0] mem_addr,
   output logic       mem_write,
   output logic       mem_type_data,
   input  logic [7:0] mem_data_in,
   input  logic       mem_data_ready
`ifdef SPELL_PREFETCH_STATS_EN
   ,
   output logic [15:0] stall_count
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      GAP
   } state_t;

   state_t          state;
   logic [7:0]      fetch_addr;
   logic            sel_q;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [7:0]      data_q [DEPTH];
   logic [7:0]      addr_q [DEPTH];
   logic            push;
   logic            pop;

   // Push/pop qualification; a redirect overrides both.
   always_comb begin
      push = (state == REQ) && !pc_load && !bus_hold && mem_data_ready;
      pop  = instr_ready && (count != '0) && !pc_load;
   end

   // Fetch FSM with registered memory select; full is only checked on IDLE->REQ.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         fetch_addr <= '0;
         sel_q      <= 1'b0;
      end else if (pc_load) begin
         state      <= IDLE;
         fetch_addr <= pc_value;
         sel_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!bus_hold && (count < CW'(DEPTH))) begin
                  state <= REQ;
                  sel_q <= 1'b1;
               end
            end
            REQ: begin
               if (bus_hold) begin
                  state <= IDLE;
                  sel_q <= 1'b0;
               end else if (mem_data_ready) begin
                  fetch_addr <= fetch_addr + 8'd1;
                  state      <= GAP;
                  sel_q      <= 1'b0;
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               sel_q <= 1'b0;
            end
         endcase
      end
   end

   // FIFO storage and occupancy; redirect empties it regardless of push/pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_q[i[PW-1:0]] <= '0;
            addr_q[i[PW-1:0]] <= '0;
         end
      end else if (pc_load) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            data_q[wr_ptr] <= mem_data_in;
            addr_q[wr_ptr] <= fetch_addr;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   assign instr_valid   = (count != '0);
   assign instr_data    = data_q[rd_ptr];
   assign instr_addr    = addr_q[rd_ptr];
   assign mem_select    = sel_q;
   assign mem_addr      = fetch_addr;
   assign mem_write     = 1'b0;
   assign mem_type_data = 1'b0;

`ifdef SPELL_PREFETCH_STATS_EN
   logic [15:0] stall_q;

   // Saturating count of cycles where the core wanted an opcode and none was ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (instr_ready && !instr_valid && !pc_load && (stall_q != '1)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_spell_prefetch.sv
// tb_spell_prefetch: directed-vector bench for spell_prefetch with a
// 1-cycle-latency code memory whose image is code[a] = a + 0xA0.
module tb_spell_prefetch;

   logic       clk = 1'b0;
   logic       rst;
   logic       pc_load;
   logic [7:0] pc_value;
   logic       bus_hold;
   logic       instr_valid;
   logic [7:0] instr_data;
   logic [7:0] instr_addr;
   logic       instr_ready;
   logic       mem_select;
   logic [7:0] mem_addr;
   logic       mem_write;
   logic       mem_type_data;
   logic [7:0] mem_data_in;
   logic       mem_data_ready;
`ifdef SPELL_PREFETCH_STATS_EN
   logic [15:0] stall_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spell_prefetch #(.DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_load        (pc_load),
      .pc_value       (pc_value),
      .bus_hold       (bus_hold),
      .instr_valid    (instr_valid),
      .instr_data     (instr_data),
      .instr_addr     (instr_addr),
      .instr_ready    (instr_ready),
      .mem_select     (mem_select),
      .mem_addr       (mem_addr),
      .mem_write      (mem_write),
      .mem_type_data  (mem_type_data),
      .mem_data_in    (mem_data_in),
      .mem_data_ready (mem_data_ready)
`ifdef SPELL_PREFETCH_STATS_EN
      ,
      .stall_count    (stall_count)
`endif
   );

   function automatic logic [7:0] code_at(input logic [7:0] a);
      return a + 8'hA0;
   endfunction

   // Memory model: ready and data one cycle after select is seen.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_data_ready <= 1'b0;
         mem_data_in    <= 8'h00;
      end else begin
         mem_data_ready <= mem_select;
         mem_data_in    <= code_at(mem_addr);
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic       pl;
      logic [7:0] pv;
      logic       bh;
      logic       rdy;
      int         n;
      logic       e_valid;
      logic       chk_data;
      logic [7:0] e_data;
      logic [7:0] e_addr;
      logic       e_sel;
      logic [7:0] e_maddr;
   } vec_t;

   localparam int NV = 18;
   vec_t vt [NV];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_addr;
      int         pops;
      bit         hit;

      //          pl  pv     bh  rdy n   val cd  data   addr   sel maddr
      vt[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0,  1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
      vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 30, 1'b1, 1'b1, 8'hA0, 8'h00, 1'b0, 8'h04};
      vt[2]  = '{1'b1, 8'hFE, 1'b0, 1'b0, 1,  1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hFE};
      vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2,  1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFE};
      vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1,  1'b1, 1'b1, 8'h9E, 8'hFE, 1'b0, 8'hFF};
      vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 30, 1'b1, 1'b1, 8'h9E, 8'hFE, 1'b0, 8'h02};
      vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1,  1'b1, 1'b1, 8'h9F, 8'hFF, 1'b0, 8'h02};
      vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1,  1'b1, 1'b1, 8'h9F, 8'hFF, 1'b1, 8'h02};
      vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1,  1'b1, 1'b1, 8'h9F, 8'hFF, 1'b0, 8'h02};
      vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5,  1'b1, 1'b1, 8'h9F, 8'hFF, 1'b0, 8'h02};
      vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1,  1'b1, 1'b1, 8'h9F, 8'hFF, 1'b1, 8'h02};
      vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1,  1'b1, 1'b1, 8'h9F, 8'hFF, 1'b1, 8'h02};
      vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1,  1'b1, 1'b1, 8'h9F, 8'hFF, 1'b0, 8'h03};
      vt[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1,  1'b1, 1'b1, 8'hA0, 8'h00, 1'b0, 8'h03};
      vt[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1,  1'b1, 1'b1, 8'hA1, 8'h01, 1'b1, 8'h03};
      vt[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1,  1'b1, 1'b1, 8'hA2, 8'h02, 1'b1, 8'h03};
      vt[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1,  1'b1, 1'b1, 8'hA3, 8'h03, 1'b0, 8'h04};
      vt[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1,  1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h04};

      rst         = 1'b1;
      pc_load     = 1'b0;
      pc_value    = 8'h00;
      bus_hold    = 1'b0;
      instr_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      chk("mem_write_tied", {15'd0, mem_write}, 16'd0);
      chk("mem_type_tied", {15'd0, mem_type_data}, 16'd0);

      // Table: fill, wrap redirect, bus_hold abort, pop order, push+pop
      for (int i = 0; i < NV; i++) begin
         pc_load     = vt[i].pl;
         pc_value    = vt[i].pv;
         bus_hold    = vt[i].bh;
         instr_ready = vt[i].rdy;
         repeat (vt[i].n) @(negedge clk);
         chk($sformatf("v%0d_valid", i), {15'd0, instr_valid}, {15'd0, vt[i].e_valid});
         chk($sformatf("v%0d_sel", i), {15'd0, mem_select}, {15'd0, vt[i].e_sel});
         chk($sformatf("v%0d_maddr", i), {8'd0, mem_addr}, {8'd0, vt[i].e_maddr});
         if (vt[i].chk_data) begin
            chk($sformatf("v%0d_data", i), {8'd0, instr_data}, {8'd0, vt[i].e_data});
            chk($sformatf("v%0d_addr", i), {8'd0, instr_addr}, {8'd0, vt[i].e_addr});
         end
      end
      pc_load = 1'b0;

      // Continuous pops: each delivered byte follows the image sequentially
      exp_addr    = 8'h04;
      pops        = 0;
      instr_ready = 1'b1;
      repeat (60) begin
         @(negedge clk);
         if (instr_valid) begin
            chk("stream_addr", {8'd0, instr_addr}, {8'd0, exp_addr});
            chk("stream_data", {8'd0, instr_data}, {8'd0, code_at(exp_addr)});
            exp_addr = exp_addr + 8'd1;
            pops++;
         end
      end
      chk("stream_progress", {15'd0, (pops >= 10)}, 16'd1);

      // Redirect with pop requested while a push is due on the same edge
      hit = 1'b0;
      for (int k = 0; k < 20 && !hit; k++) begin
         @(negedge clk);
         if (mem_select && mem_data_ready) hit = 1'b1;
      end
      chk("push_due_found", {15'd0, hit}, 16'd1);
      pc_load  = 1'b1;
      pc_value = 8'h40;
      @(negedge clk);
      chk("redir_valid", {15'd0, instr_valid}, 16'd0);
      chk("redir_maddr", {8'd0, mem_addr}, 16'h0040);
      pc_load     = 1'b0;
      instr_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("redir_e2_valid", {15'd0, instr_valid}, 16'd0);
      @(negedge clk);
      chk("redir_e3_valid", {15'd0, instr_valid}, 16'd1);
      chk("redir_e3_addr", {8'd0, instr_addr}, 16'h0040);
      chk("redir_e3_data", {8'd0, instr_data}, 16'h00E0);

      // Asynchronous reset while a request is outstanding
      hit = 1'b0;
      for (int k = 0; k < 10 && !hit; k++) begin
         @(negedge clk);
         if (mem_select) hit = 1'b1;
      end
      chk("sel_found", {15'd0, hit}, 16'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_sel", {15'd0, mem_select}, 16'd0);
      chk("async_rst_valid", {15'd0, instr_valid}, 16'd0);

      // Starved core with bus held: FIFO stays empty for 10 cycles
      instr_ready = 1'b1;
      bus_hold    = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("starve_valid", {15'd0, instr_valid}, 16'd0);
      chk("starve_sel", {15'd0, mem_select}, 16'd0);
`ifdef SPELL_PREFETCH_STATS_EN
      chk("stall_10", stall_count, 16'd10);
      force dut.stall_q = 16'hFFFF;
      @(negedge clk);
      release dut.stall_q;
      repeat (3) @(negedge clk);
      chk("stall_sat", stall_count, 16'hFFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
